sid_i2s_tx: RTL and testbench

Audio output serializer that sits directly downstream of the SID filter/volume stage. It captures each 16-bit unsigned mixed sample on the filter's sample strobe and converts it to two's complement. It holds the sample in a one-deep buffer and transmits it as a standard Philips I2S stream (16-bit slots, identical left and right) to an external DAC codec. Overrun and underrun pulses report any mismatch between the SID sample rate and the I2S frame rate.

---
 rtl/sid_i2s_tx.sv | 89 ++++++++
 tb/tb_sid_i2s_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_i2s_tx.sv
// SID mixer output to Philips I2S: 16-bit slots, same word on left and right, one-deep sample buffer.
// Latency: a sample buffered while empty is the left MSB in slot 1 of the next frame; no backpressure, overrun/underrun pulses flag rate mismatch.
module sid_i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        enable,
    output logic        i2s_sclk,
    output logic        i2s_lrck,
    output logic        i2s_sd,
    output logic        frame_start,
    output logic        overrun,
    output logic        underrun
);

    logic [7:0]  div_cnt;
    logic [4:0]  slot;
    logic [15:0] hold;
    logic [15:0] word;
    logic        hold_full;

    logic        div_tc;
    logic        sclk_fall;
    logic [4:0]  slot_nxt;
    logic        load;
    logic [3:0]  bit_idx;

    assign div_tc    = (div_cnt == 8'(CLK_DIV - 1));
    assign sclk_fall = div_tc & i2s_sclk;
    assign slot_nxt  = slot + 5'd1;
    assign load      = sclk_fall & (slot_nxt == 5'd0);
    // Slot s carries word bit (16 - s) mod 16; slot 0 reads the outgoing word's LSB before the load lands.
    assign bit_idx   = 4'd0 - slot_nxt[3:0];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div_cnt     <= 8'd0;
            slot        <= 5'd31;
            i2s_sclk    <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_sd      <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            hold        <= 16'd0;
            hold_full   <= 1'b0;
            word        <= 16'd0;
        end else if (!enable) begin
            div_cnt     <= 8'd0;
            slot        <= 5'd31;
            i2s_sclk    <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_sd      <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load & ~hold_full;
            overrun     <= sample_valid & hold_full & ~load;

            div_cnt <= div_tc ? 8'd0 : div_cnt + 8'd1;
            if (div_tc)
                i2s_sclk <= ~i2s_sclk;

            if (sclk_fall) begin
                slot     <= slot_nxt;
                i2s_lrck <= slot_nxt[4];
                i2s_sd   <= word[bit_idx];
            end

            if (load && hold_full) begin
                word      <= hold;
                hold_full <= 1'b0;
            end

            // A strobe coinciding with the load refills the buffer after the old contents moved out.
            if (sample_valid) begin
                hold      <= sample_in ^ 16'h8000;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Randomized and directed bench for sid_i2s_tx against a frame-level reference model.
module tb_sid_i2s_tx;

    localparam int CD = 2;

    logic        clk;
    logic        n_reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        enable;
    logic        i2s_sclk;
    logic        i2s_lrck;
    logic        i2s_sd;
    logic        frame_start;
    logic        overrun;
    logic        underrun;

    sid_i2s_tx #(.CLK_DIV(CD)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .enable       (enable),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sd       (i2s_sd),
        .frame_start  (frame_start),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_bad = 0;

    // reference model state: mt = clk edges since reset/enable rise
    int          mt;
    int          mslot;
    logic [15:0] m_word;
    logic [15:0] m_hold;
    logic        m_full;
    logic        seq [32];
    logic        e_sclk, e_lrck, e_sd, e_fs, e_ov, e_un;

    // receiver that reassembles words from the DUT's serial data on sclk rises
    logic        rx [32];
    logic        have_prev;
    logic [15:0] rx_left[$];
    logic [15:0] rx_right[$];

    int cnt_ov = 0;
    int cnt_un = 0;
    int cnt_fs = 0;
    int last_fs_t = -1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", tag, act, exp, mt);
        end
    endtask

    task automatic model_reset();
        mt = 0; mslot = -1; have_prev = 1'b0;
        m_word = 16'd0; m_hold = 16'd0; m_full = 1'b0;
        e_sclk = 0; e_lrck = 0; e_sd = 0; e_fs = 0; e_ov = 0; e_un = 0;
        for (int i = 0; i < 32; i++) begin
            seq[i] = 1'b0;
            rx[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic en, input logic sv, input logic [15:0] sin);
        int  k;
        int  s;
        logic ld;
        e_fs = 0; e_ov = 0; e_un = 0; ld = 0;
        if (!en) begin
            mt = 0; mslot = -1; have_prev = 1'b0;
            e_sclk = 0; e_lrck = 0; e_sd = 0;
            m_full = 1'b0;
        end else begin
            mt++;
            if (mt % CD == 0) begin
                k = mt / CD;
                e_sclk = (k % 2 == 1);
                if (k % 2 == 0) begin
                    s = (k / 2 - 1) % 32;
                    if (s == 0) begin
                        ld = 1; e_fs = 1;
                        seq[0] = m_word[0];
                        if (m_full) begin
                            m_word = m_hold;
                            m_full = 1'b0;
                        end else begin
                            e_un = 1;
                        end
                        for (int i = 0; i < 16; i++) seq[1 + i] = m_word[15 - i];
                        for (int i = 0; i < 15; i++) seq[17 + i] = m_word[15 - i];
                    end
                    mslot  = s;
                    e_lrck = (s >= 16);
                    e_sd   = seq[s];
                end
            end
            if (sv) begin
                if (m_full && !ld) e_ov = 1;
                m_hold = sin ^ 16'h8000;
                m_full = 1'b1;
            end
        end
    endtask

    task automatic rx_sample();
        logic [15:0] w;
        if (enable && mt % CD == 0 && (mt / CD) % 2 == 1 && mslot >= 0) begin
            rx[mslot] = i2s_sd;
            if (mslot == 16) begin
                w = 16'd0;
                for (int i = 1; i <= 16; i++) w = {w[14:0], rx[i]};
                rx_left.push_back(w);
            end
            if (mslot == 0 && have_prev) begin
                w = 16'd0;
                for (int i = 17; i <= 31; i++) w = {w[14:0], rx[i]};
                w = {w[14:0], i2s_sd};
                rx_right.push_back(w);
            end
            if (mslot == 31) have_prev = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (n_reset) begin
            model_step(enable, sample_valid, sample_in);
            rx_sample();
        end
        chk("sclk",        32'(i2s_sclk),    32'(e_sclk));
        chk("lrck",        32'(i2s_lrck),    32'(e_lrck));
        chk("sd",          32'(i2s_sd),      32'(e_sd));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("overrun",     32'(overrun),     32'(e_ov));
        chk("underrun",    32'(underrun),    32'(e_un));
        if (overrun) cnt_ov++;
        if (underrun) cnt_un++;
        if (frame_start) begin
            cnt_fs++;
            last_fs_t = mt;
        end
    endtask

    task automatic step(input logic sv, input logic [15:0] s);
        sample_valid = sv;
        sample_in    = s;
        tick();
    endtask

    task automatic run_to(input int target);
        while (mt < target) step(1'b0, 16'h0);
    endtask

    task automatic send_at(input int t, input logic [15:0] s);
        run_to(t - 1);
        step(1'b1, s);
    endtask

    logic [15:0] exp_words [7];

    initial begin
        n_reset = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample_in = 16'h0;
        model_reset();
        repeat (3) tick();
        n_reset = 1'b1;

        // frame n loads at edge 4 + 128*n
        send_at(2, 16'h0000);
        run_to(10);
        chk("first_fs_edge", 32'(last_fs_t), 32'd4);
        send_at(60,  16'hFFFF);
        send_at(200, 16'h1234);
        send_at(300, 16'hAAAA);
        send_at(340, 16'h5555);
        run_to(400);
        chk("ov_count", 32'(cnt_ov), 32'd1);
        send_at(600, 16'h0F0F);
        send_at(644, 16'h00FF);
        run_to(937);

        exp_words = '{16'h8000, 16'h7FFF, 16'h9234, 16'hD555, 16'hD555, 16'h8F0F, 16'h80FF};
        chk("left_count",  32'(rx_left.size()),  32'd7);
        chk("right_count", 32'(rx_right.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < rx_left.size())  chk($sformatf("left%0d", i),  32'(rx_left[i]),  32'(exp_words[i]));
            if (i < rx_right.size()) chk($sformatf("right%0d", i), 32'(rx_right[i]), 32'(exp_words[i]));
        end
        chk("un_count", 32'(cnt_un), 32'd2);
        chk("ov_total", 32'(cnt_ov), 32'd1);
        chk("fs_count", 32'(cnt_fs), 32'd8);

        // drop enable mid-slot 9 of frame 7, then restart with an empty buffer
        sample_valid = 1'b0;
        enable = 1'b0;
        repeat (11) tick();
        enable = 1'b1;
        run_to(6);
        chk("restart_fs_edge", 32'(last_fs_t), 32'd4);
        chk("restart_un", 32'(cnt_un), 32'd3);

        // randomized phase
        rx_left.delete();
        rx_right.delete();
        for (int it = 0; it < 5000; it++) begin
            int r;
            r = $urandom_range(0, 999);
            if (it == 2500) begin
                n_reset = 1'b0;
                #1;
                chk("arst_sclk", 32'(i2s_sclk), 32'd0);
                chk("arst_lrck", 32'(i2s_lrck), 32'd0);
                chk("arst_sd",   32'(i2s_sd),   32'd0);
                chk("arst_flags", 32'({frame_start, overrun, underrun}), 32'd0);
                model_reset();
                sample_valid = 1'b0;
                repeat (2) tick();
                n_reset = 1'b1;
            end else if (r == 500) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 30)) step(1'($urandom_range(0, 1)), 16'($urandom));
                enable = 1'b1;
            end else if (r < 12) begin
                step(1'b1, 16'($urandom));
            end else begin
                step(1'b0, 16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
